// File: rtl/toy_fetch_imem_rsp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : toy_pack (package)
// Brief    : Shared widths, line offset and response record for the fetch
//            instruction-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package toy_pack;

  localparam int ADDR_WIDTH          = 32;
  localparam int INST_WIDTH          = 32;
  localparam int FETCH_WRITE_CHANNEL = 4;
  localparam int LINE_WIDTH          = FETCH_WRITE_CHANNEL * INST_WIDTH;
  localparam int SLOT_BITS           = $clog2(FETCH_WRITE_CHANNEL);
  // Byte offset of the line index inside a PC.
  localparam int OFF                 = SLOT_BITS + 2;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]          pc;
    logic [LINE_WIDTH-1:0]          inst;
    logic [FETCH_WRITE_CHANNEL-1:0] mask;
  } fetch_rsp_t;

  // Slots at or above the PC's word offset are valid for the fetcher.
  function automatic logic [FETCH_WRITE_CHANNEL-1:0] slot_mask(input logic [SLOT_BITS-1:0] off);
    return {FETCH_WRITE_CHANNEL{1'b1}} << off;
  endfunction

endpackage
`default_nettype wire

// File: rtl/toy_fetch_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : toy_fetch_rsp_fifo
// Brief    : Synchronous FIFO of fetch responses with a clear that empties
//            the queue but still keeps a write issued in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module toy_fetch_rsp_fifo
  import toy_pack::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       wr_en,
  input  fetch_rsp_t wr_data,
  input  logic       rd_en,
  output fetch_rsp_t rd_data,
  output logic       vld
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_rsp_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          do_wr;
  logic          do_rd;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign vld     = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & vld;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking; clear restarts at slot 0 with the new write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= wr_en ? bump('0) : '0;
      count  <= wr_en ? CW'(1) : '0;
    end else begin
      if (do_wr) wr_ptr <= bump(wr_ptr);
      if (do_rd) rd_ptr <= bump(rd_ptr);
      if (do_wr && !do_rd)      count <= count + CW'(1);
      else if (!do_wr && do_rd) count <= count - CW'(1);
    end
  end

  // Entry storage, not reset
  always_ff @(posedge clk) begin
    if (clr && wr_en) mem[0]      <= wr_data;
    else if (do_wr)   mem[wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/toy_fetch_imem_rsp.sv
`default_nettype none
// ============================================================================
// Module   : toy_fetch_imem_rsp
// Brief    : Fetch-PC memory responder. Returns one aligned instruction line
//            plus slot mask per accepted PC through a fixed-latency pipeline
//            and an output FIFO, with credit-based request flow control.
//            Optional macro TOY_FETCH_RSP_BYPASS_EN lets a response skip the
//            FIFO when it is empty and the consumer is ready.
// Revision : 1.0 - initial release
// ============================================================================
module toy_fetch_imem_rsp
  import toy_pack::*;
#(
  parameter int MEM_LINES  = 1024,
  parameter int RD_LATENCY = 2,
  parameter int OSTD_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,   // active-high despite the name
  input  logic [ADDR_WIDTH-1:0]          mem_req_addr,
  input  logic                           mem_req_vld,
  output logic                           mem_req_rdy,
  input  logic                           flush_en,
  output logic                           rsp_vld,
  input  logic                           rsp_rdy,
  output logic [ADDR_WIDTH-1:0]          rsp_pc,
  output logic [LINE_WIDTH-1:0]          rsp_inst,
  output logic [FETCH_WRITE_CHANNEL-1:0] rsp_mask,
  input  logic                           ld_en,
  input  logic [$clog2(MEM_LINES)-1:0]   ld_idx,
  input  logic [LINE_WIDTH-1:0]          ld_data
);

  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int CNT_W = $clog2(OSTD_DEPTH + 1);
  // With a single-cycle latency the pipeline output is the request of this
  // very cycle, so a flush must not drop it.
  localparam bit PIPE_HOLDS_OLD = (RD_LATENCY > 1);

  logic [LINE_WIDTH-1:0] store [MEM_LINES];
  logic [IDX_W-1:0]      rd_idx;
  logic [CNT_W-1:0]      ostd_cnt;
  logic [CNT_W-1:0]      ostd_cnt_nxt;
  logic                  accept;
  logic                  pop;
  logic                  bypass;
  logic                  fifo_wr;
  logic                  fifo_vld;
  logic                  pipe_vld;
  fetch_rsp_t            req_rsp;
  fetch_rsp_t            pipe_rsp;
  fetch_rsp_t            fifo_rsp;
  fetch_rsp_t            out_rsp;

  assign rd_idx      = mem_req_addr[OFF+IDX_W-1:OFF];
  assign mem_req_rdy = (ostd_cnt < CNT_W'(OSTD_DEPTH)) | flush_en;
  assign accept      = mem_req_vld & mem_req_rdy;
  assign req_rsp     = '{pc:   mem_req_addr,
                         inst: store[rd_idx],
                         mask: slot_mask(mem_req_addr[OFF-1:2])};

  // Loader port; a same-cycle read sees the pre-write contents
  always_ff @(posedge clk) begin
    if (ld_en) store[ld_idx] <= ld_data;
  end

  generate
    if (RD_LATENCY > 1) begin : g_pipe
      localparam int STAGES = RD_LATENCY - 1;
      logic [STAGES-1:0] stage_vld;
      fetch_rsp_t        stage_rsp [STAGES];

      // Valid shift chain; a flush kills everything already in flight
      always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
          stage_vld <= '0;
        end else begin
          stage_vld[0] <= accept;
          for (int i = 1; i < STAGES; i++) begin
            stage_vld[i] <= stage_vld[i-1] & ~flush_en;
          end
        end
      end

      // Payload shift chain, captured at accept time
      always_ff @(posedge clk) begin
        stage_rsp[0] <= req_rsp;
        for (int i = 1; i < STAGES; i++) begin
          stage_rsp[i] <= stage_rsp[i-1];
        end
      end

      assign pipe_vld = stage_vld[STAGES-1];
      assign pipe_rsp = stage_rsp[STAGES-1];
    end else begin : g_no_pipe
      assign pipe_vld = accept;
      assign pipe_rsp = req_rsp;
    end
  endgenerate

`ifdef TOY_FETCH_RSP_BYPASS_EN
  assign bypass = pipe_vld & ~fifo_vld & rsp_rdy & ~flush_en;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_wr = pipe_vld & ~bypass & ~(flush_en & PIPE_HOLDS_OLD);

  toy_fetch_rsp_fifo #(
    .DEPTH (OSTD_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst_n),
    .clr     (flush_en),
    .wr_en   (fifo_wr),
    .wr_data (pipe_rsp),
    .rd_en   (rsp_rdy),
    .rd_data (fifo_rsp),
    .vld     (fifo_vld)
  );

  assign rsp_vld  = fifo_vld | bypass;
  assign out_rsp  = fifo_vld ? fifo_rsp : pipe_rsp;
  assign rsp_pc   = out_rsp.pc;
  assign rsp_inst = out_rsp.inst;
  assign rsp_mask = out_rsp.mask;
  assign pop      = rsp_vld & rsp_rdy;

  // Next outstanding count; a flush leaves only the redirect request
  always_comb begin
    ostd_cnt_nxt = ostd_cnt;
    if (flush_en)             ostd_cnt_nxt = accept ? CNT_W'(1) : '0;
    else if (accept && !pop)  ostd_cnt_nxt = ostd_cnt + CNT_W'(1);
    else if (!accept && pop)  ostd_cnt_nxt = ostd_cnt - CNT_W'(1);
  end

  // Credit counter register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) ostd_cnt <= '0;
    else       ostd_cnt <= ostd_cnt_nxt;
  end

endmodule
`default_nettype wire
